// File: rtl/serial_deframer_pkg.sv
// -----------------------------------------------------------------------------
// serial_deframer_pkg
// Shared types and default parameter values for the serial deframer.
//   state_t             : deframer FSM states (HUNT searches for sync,
//                         PAYLOAD assembles bytes)
//   DATA_W_DEFAULT      : payload byte width in bits
//   SYNC_WORD_DEFAULT   : frame sync pattern (nonzero)
//   FRAME_BYTES_DEFAULT : payload bytes per frame before re-hunting
// -----------------------------------------------------------------------------
package serial_deframer_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam int         DATA_W_DEFAULT      = 8;
  localparam logic [7:0] SYNC_WORD_DEFAULT   = 8'hA5;
  localparam int         FRAME_BYTES_DEFAULT = 4;

endpackage

// File: rtl/serial_deframer_deser_shift.sv
// -----------------------------------------------------------------------------
// deser_shift
// Width-parameterised serial-in shift register, MSB first.
// Ports:
//   clk : clock, rising edge
//   clr : synchronous clear to zero (has priority over en)
//   en  : shift enable; q <= {q[W-2:0], din}
//   din : serial input bit
//   q   : register contents
// -----------------------------------------------------------------------------
module deser_shift
  import serial_deframer_pkg::*;
#(
  parameter int W = DATA_W_DEFAULT
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], din};
    end
  end

endmodule

// File: rtl/serial_deframer.sv
// -----------------------------------------------------------------------------
// serial_deframer
// Hunts a serial bit stream for SYNC_WORD, then assembles FRAME_BYTES payload
// bytes (MSB first) and hands them out through a one-deep valid/ready
// register. A byte completing while the register is still full is dropped and
// flags a sticky overflow. After the last byte of a frame the deframer goes
// back to hunting.
//
// Optional feature macro: SERIAL_DEFRAMER_PARITY_EN
//   When defined, every payload byte is followed by one even-parity bit, the
//   byte completes on that bit, and parity_err pulses for one cycle after a
//   byte whose 9 bits XOR to 1.
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : synchronous active-high reset
//   d          : serial data bit, MSB first
//   d_valid    : d is sampled only when high
//   out_data   : assembled payload byte
//   out_valid  : out_data holds an unconsumed byte
//   out_ready  : consumer accepts out_data when out_valid && out_ready
//   locked     : high while in PAYLOAD
//   overflow   : sticky, a completed byte was dropped (cleared by reset only)
//   parity_err : one-cycle parity error pulse (parity build only)
// -----------------------------------------------------------------------------
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] SYNC_WORD   = DATA_W'(SYNC_WORD_DEFAULT),
  parameter int                FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d,
  input  logic              d_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              overflow
`ifdef SERIAL_DEFRAMER_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef SERIAL_DEFRAMER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int BITS_PER_BYTE = DATA_W + PAR_BITS;
  localparam int BIT_CW        = $clog2(BITS_PER_BYTE + 1);
  localparam int BYTE_CW       = $clog2(FRAME_BYTES + 1);

  state_t             state;
  state_t             state_next;
  logic [BIT_CW-1:0]  bit_cnt;
  logic [BYTE_CW-1:0] byte_cnt;
  logic [DATA_W-1:0]  win_q;
  logic [DATA_W-1:0]  sreg_q;
  logic [DATA_W-1:0]  byte_val;
  logic               in_payload;
  logic               sync_hit;
  logic               bit_last;
  logic               byte_done;
  logic               frame_done;
  logic               load;
  logic               drop;
  logic               win_en;
  logic               win_clr;
  logic               sreg_en;

  assign in_payload = (state == PAYLOAD);
  assign locked     = in_payload;

  // Sync compares against the window as it will look after this bit shifts in.
  assign sync_hit   = !in_payload && d_valid && ({win_q[DATA_W-2:0], d} == SYNC_WORD);
  assign bit_last   = (bit_cnt == BIT_CW'(BITS_PER_BYTE - 1));
  assign byte_done  = in_payload && d_valid && bit_last;
  assign frame_done = byte_done && (byte_cnt == BYTE_CW'(FRAME_BYTES - 1));
  assign load       = byte_done && (!out_valid || out_ready);
  assign drop       = byte_done && out_valid && !out_ready;

  assign win_en     = !in_payload && d_valid;
  assign win_clr    = reset || frame_done;

`ifdef SERIAL_DEFRAMER_PARITY_EN
  // The parity bit is not shifted in, so the register already holds the byte.
  assign sreg_en    = in_payload && d_valid && !bit_last;
  assign byte_val   = sreg_q;
`else
  // The completing bit is merged combinationally so the byte loads this cycle.
  assign sreg_en    = in_payload && d_valid;
  assign byte_val   = {sreg_q[DATA_W-2:0], d};
`endif

  // The window MSB only matters through the post-shift compare, and the data
  // MSB is shifted out in the default build.
  logic unused_msb;
  assign unused_msb = win_q[DATA_W-1] ^ sreg_q[DATA_W-1];

  deser_shift #(.W(DATA_W)) u_window (
    .clk (clk),
    .clr (win_clr),
    .en  (win_en),
    .din (d),
    .q   (win_q)
  );

  deser_shift #(.W(DATA_W)) u_data (
    .clk (clk),
    .clr (reset),
    .en  (sreg_en),
    .din (d),
    .q   (sreg_q)
  );

  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (sync_hit)   state_next = PAYLOAD;
      PAYLOAD: if (frame_done) state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;

      if (sync_hit) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end else if (in_payload && d_valid) begin
        bit_cnt <= bit_last ? '0 : bit_cnt + BIT_CW'(1);
        // Dropped bytes still count toward the frame length.
        if (bit_last) begin
          byte_cnt <= frame_done ? '0 : byte_cnt + BYTE_CW'(1);
        end
      end

      // A load wins over an accept in the same cycle: out_valid stays high.
      if (load) begin
        out_data  <= byte_val;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SERIAL_DEFRAMER_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= byte_done && (^{sreg_q, d});
    end
  end
`endif

endmodule
